fadsu_nibble_seq: RTL and testbench



---
 rtl/fadsu_nibble_seq_pkg.sv | 23 ++
 rtl/fadsu_nibble_seq_if.sv | 35 +++
 rtl/fadsu_nibble_seq_adsu4_slice.sv | 41 ++++
 rtl/fadsu_nibble_seq.sv | 141 ++++++++++++++
 tb/tb_fadsu_nibble_seq.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/fadsu_nibble_seq_pkg.sv
// fadsu_nibble_seq_pkg
// Shared definitions for the nibble-serial add/subtract unit:
//   NIB_W      - width of the add/sub slice (one nibble)
//   state_e    - controller states (IDLE, RUN)
//   idx_width  - bit width of the nibble index counter for a given WIDTH
package fadsu_nibble_seq_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // $clog2(WIDTH/NIB_W), but never narrower than one bit so WIDTH=4 still
  // gets a legal counter.
  function automatic int idx_width(input int width);
    int w;
    w = $clog2(width / NIB_W);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fadsu_nibble_seq_if.sv
// fadsu_nibble_seq_if
// Request/result bundle of the nibble-serial add/subtract unit.
//   START, CON, A, B, BCI : request side (driven by master)
//   BUSY, DONE, S, BCO    : result side (driven by slave)
//   OFL                   : signed overflow, present only when
//                           FADSU_NIBBLE_SEQ_OFL_EN is defined
// Modports: master (requester), slave (the unit itself).
interface fadsu_nibble_seq_if #(
  parameter int WIDTH = 16
);

  logic             START;
  logic             CON;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BCI;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] S;
  logic             BCO;
`ifdef FADSU_NIBBLE_SEQ_OFL_EN
  logic             OFL;

  modport master (output START, CON, A, B, BCI,
                  input  BUSY, DONE, S, BCO, OFL);
  modport slave  (input  START, CON, A, B, BCI,
                  output BUSY, DONE, S, BCO, OFL);
`else
  modport master (output START, CON, A, B, BCI,
                  input  BUSY, DONE, S, BCO);
  modport slave  (input  START, CON, A, B, BCI,
                  output BUSY, DONE, S, BCO);
`endif

endinterface

// File: rtl/fadsu_nibble_seq_adsu4_slice.sv
// fadsu_nibble_seq_adsu4_slice (the adsu4_slice cell)
// Combinational 4-bit add/subtract slice, same per-bit logic as the
// 4-bit carry-chain add/sub cell.
//   A, B : nibble operands
//   CON  : 1 = add, 0 = subtract (B inverted)
//   CI   : carry in
//   S    : nibble sum
//   CO   : carry out of bit 3
//   C3   : carry into bit 3 (used for signed overflow)
module fadsu_nibble_seq_adsu4_slice
  import fadsu_nibble_seq_pkg::*;
(
  input  logic [NIB_W-1:0] A,
  input  logic [NIB_W-1:0] B,
  input  logic             CON,
  input  logic             CI,
  output logic [NIB_W-1:0] S,
  output logic             CO,
  output logic             C3
);

  logic [NIB_W-1:0] beff;
  logic [NIB_W:0]   c;

  // CON XNOR B: pass B when adding, invert it when subtracting
  assign beff = ~({NIB_W{CON}} ^ B);

  always_comb begin
    c    = '0;
    S    = '0;
    c[0] = CI;
    for (int i = 0; i < NIB_W; i++) begin
      S[i]   = A[i] ^ beff[i] ^ c[i];
      c[i+1] = (A[i] & beff[i]) | (A[i] & c[i]) | (beff[i] & c[i]);
    end
  end

  assign CO = c[NIB_W];
  assign C3 = c[NIB_W-1];

endmodule

// File: rtl/fadsu_nibble_seq.sv
// fadsu_nibble_seq
// WIDTH-bit add/subtract computed one nibble per clock through a single
// 4-bit slice; the inter-nibble carry lives in a register.
//   CK  : rising-edge clock
//   CD  : synchronous active-high clear, dominates everything
//   bus : slave side of fadsu_nibble_seq_if (START/CON/A/B/BCI in,
//         BUSY/DONE/S/BCO out, plus OFL with FADSU_NIBBLE_SEQ_OFL_EN)
// Optional feature: define FADSU_NIBBLE_SEQ_OFL_EN to add the signed
// overflow flag OFL.
module fadsu_nibble_seq
  import fadsu_nibble_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               CK,
  input  logic               CD,
  fadsu_nibble_seq_if.slave  bus
);

  localparam int N  = WIDTH / NIB_W;
  localparam int IW = idx_width(WIDTH);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  localparam logic [0:0] S_IDLE = ST_IDLE;
  localparam logic [0:0] S_RUN  = ST_RUN;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             con_q, con_d;
  logic             carry_q, carry_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             bco_q, bco_d;
  logic             done_q, done_d;

  logic [NIB_W-1:0] slice_s;
  logic             slice_co;
  logic             slice_c3;

  fadsu_nibble_seq_adsu4_slice u_slice (
    .A   (a_q[NIB_W-1:0]),
    .B   (b_q[NIB_W-1:0]),
    .CON (con_q),
    .CI  (carry_q),
    .S   (slice_s),
    .CO  (slice_co),
    .C3  (slice_c3)
  );

`ifdef FADSU_NIBBLE_SEQ_OFL_EN
  logic ofl_q, ofl_d;
`else
  logic unused_c3;
  assign unused_c3 = slice_c3;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    con_d   = con_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    s_d     = s_q;
    bco_d   = bco_q;
    done_d  = 1'b0;
`ifdef FADSU_NIBBLE_SEQ_OFL_EN
    ofl_d   = ofl_q;
`endif
    case (state_q)
      S_IDLE: begin
        // DONE cycle is an IDLE cycle, so back-to-back starts fall out here
        if (bus.START) begin
          a_d     = bus.A;
          b_d     = bus.B;
          con_d   = bus.CON;
          carry_d = bus.BCI;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // New nibble enters at the top; after N shifts nibble 0 sits at the bottom
        s_d     = (s_q >> NIB_W) | (WIDTH'(slice_s) << (WIDTH - NIB_W));
        a_d     = a_q >> NIB_W;
        b_d     = b_q >> NIB_W;
        carry_d = slice_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          bco_d   = slice_co;
          done_d  = 1'b1;
          state_d = S_IDLE;
`ifdef FADSU_NIBBLE_SEQ_OFL_EN
          ofl_d   = slice_c3 ^ slice_co;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (CD) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      con_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      s_q     <= '0;
      bco_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef FADSU_NIBBLE_SEQ_OFL_EN
      ofl_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      con_q   <= con_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      bco_q   <= bco_d;
      done_q  <= done_d;
`ifdef FADSU_NIBBLE_SEQ_OFL_EN
      ofl_q   <= ofl_d;
`endif
    end
  end

  assign bus.BUSY = (state_q == S_RUN);
  assign bus.DONE = done_q;
  assign bus.S    = s_q;
  assign bus.BCO  = bco_q;
`ifdef FADSU_NIBBLE_SEQ_OFL_EN
  assign bus.OFL  = ofl_q;
`endif

endmodule

// File: tb/tb_fadsu_nibble_seq.sv
// tb_fadsu_nibble_seq
// Directed checks of fadsu_nibble_seq at WIDTH=16 with hand-computed
// results. OFL is checked as well when FADSU_NIBBLE_SEQ_OFL_EN is defined.
module tb_fadsu_nibble_seq;

  localparam int WIDTH = 16;

  logic clk;
  logic cd;
  int   n_checks;
  int   n_errors;

  fadsu_nibble_seq_if #(.WIDTH(WIDTH)) bus ();

  fadsu_nibble_seq #(.WIDTH(WIDTH)) u_dut (
    .CK  (clk),
    .CD  (cd),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one clock and settle just past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic start, input logic [15:0] a, input logic [15:0] b,
                       input logic con, input logic bci);
    bus.START = start;
    bus.A     = a;
    bus.B     = b;
    bus.CON   = con;
    bus.BCI   = bci;
  endtask

  // ticks until DONE, returns cycles from the previous edge; -1 if it never comes
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.DONE) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] exp_s,
                              input logic exp_bco, input logic exp_ofl);
    check({tag, "_s"},    32'(bus.S), 32'(exp_s));
    check({tag, "_bco"},  32'(bus.BCO), 32'(exp_bco));
    check({tag, "_busy"}, 32'(bus.BUSY), 32'd0);
`ifdef FADSU_NIBBLE_SEQ_OFL_EN
    check({tag, "_ofl"},  32'(bus.OFL), 32'(exp_ofl));
`else
    if (exp_ofl === 1'bx) $display("note: unexpected ofl expectation in %s", tag);
`endif
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic con, input logic bci,
                        input logic [15:0] exp_s, input logic exp_bco, input logic exp_ofl);
    int cyc;
    drive(1'b1, a, b, con, bci);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    check({tag, "_busy_after_accept"}, 32'(bus.BUSY), 32'd1);
    wait_done(cyc);
    check({tag, "_latency"}, 32'(cyc), 32'd4);
    check_result(tag, exp_s, exp_bco, exp_ofl);
    tick();
    check({tag, "_done_one_cycle"}, 32'(bus.DONE), 32'd0);
  endtask

  initial begin
    int cyc;
    int busy_cnt;
    n_checks = 0;
    n_errors = 0;
    cd = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

    // reset held two cycles, then idle
    tick();
    tick();
    check("rst_state", 32'({bus.BUSY, bus.DONE, bus.BCO, bus.S}), 32'd0);
    cd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_state", 32'({bus.BUSY, bus.DONE, bus.BCO, bus.S}), 32'd0);
    end
`ifdef FADSU_NIBBLE_SEQ_OFL_EN
    check("rst_ofl", 32'(bus.OFL), 32'd0);
`endif

    // add with BUSY counted over the run
    drive(1'b1, 16'h1234, 16'h0FFF, 1'b1, 1'b0);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    busy_cnt = 0;
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      if (bus.BUSY) busy_cnt++;
      tick();
      if (bus.DONE) begin
        cyc = i;
        break;
      end
    end
    check("add_latency", 32'(cyc), 32'd4);
    check("add_busy_cycles", 32'(busy_cnt), 32'd4);
    check_result("add", 16'h2233, 1'b0, 1'b0);
    tick();
    check("add_done_one_cycle", 32'(bus.DONE), 32'd0);

    run_op("sub_borrow",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_noborrow",16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    run_op("ripple",      16'hFFFF, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_op("add_ci",      16'hABCD, 16'h1111, 1'b1, 1'b1, 16'hBCDF, 1'b0, 1'b0);
    run_op("sub_ofl",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("add_ofl",     16'h7FFF, 16'h0001, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);

    // START mid-run ignored; START in DONE cycle accepted
    drive(1'b1, 16'h1234, 16'h0FFF, 1'b1, 1'b0);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'hAAAA, 16'h5555, 1'b0, 1'b1);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    wait_done(cyc);
    check("midstart_latency", 32'(cyc), 32'd2);
    check_result("midstart", 16'h2233, 1'b0, 1'b0);
    drive(1'b1, 16'h0007, 16'h0005, 1'b0, 1'b1);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    check("b2b_busy", 32'(bus.BUSY), 32'd1);
    wait_done(cyc);
    check("b2b_latency", 32'(cyc), 32'd4);
    check_result("b2b", 16'h0002, 1'b1, 1'b0);
    tick();

    // CD during the 2nd RUN cycle aborts the run
    drive(1'b1, 16'h1234, 16'h0FFF, 1'b1, 1'b0);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick();
    cd = 1'b1;
    drive(1'b1, 16'h1111, 16'h1111, 1'b1, 1'b0);
    tick();
    cd = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    check("abort_state", 32'({bus.BUSY, bus.DONE, bus.BCO, bus.S}), 32'd0);
`ifdef FADSU_NIBBLE_SEQ_OFL_EN
    check("abort_ofl", 32'(bus.OFL), 32'd0);
`endif
    cyc = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.DONE || bus.BUSY) cyc++;
    end
    check("abort_no_done", 32'(cyc), 32'd0);
    check("abort_s_held", 32'(bus.S), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
